// File: rtl/mips_mc_ctrl.sv
//------------------------------------------------------------------------------
// mips_mc_ctrl
//
// Main control unit for the multicycle MIPS datapath. A Moore FSM walks each
// instruction through fetch, decode, execute, memory and writeback, taking
// 3 to 5 cycles. It drives every mux select and write enable in the datapath
// from the current state. The only exception is pc_en, which also looks at the
// ALU zero flag so that a taken beq can load the PC.
//
// Optional feature (compile-time macro MEM_WAIT_EN):
//   Defined   : FETCH, MEMRD and MEMWR hold their state and outputs while
//               mem_ready=0. If a state is held for MEM_TIMEOUT cycles, the
//               sticky mem_err flag sets and the FSM moves on as if the
//               memory had answered.
//   Undefined : mem_ready is ignored, every state lasts one cycle, and
//               mem_err is tied to 0.
//
// Parameters:
//   MEM_TIMEOUT  cycles allowed in one memory state before mem_err
//                (used only with MEM_WAIT_EN)
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-low reset
//   opcode[5:0] in   instruction[31:26] from the instruction register
//   funct[5:0]  in   instruction[5:0] from the instruction register
//   zero        in   ALU zero flag
//   mem_ready   in   memory access complete this cycle
//   iord        out  memory address select: 0=PC, 1=ALUOut
//   mem_write   out  data memory write enable
//   ir_write    out  instruction register load
//   reg_dst     out  destination register: 0=rt, 1=rd
//   mem_to_reg  out  writeback source: 0=ALUOut, 1=data register
//   reg_write   out  register file write enable
//   alu_src_a   out  ALU A operand: 0=PC, 1=A
//   alu_src_b   out  ALU B operand: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
//   alu_ctrl    out  010 add, 110 sub, 000 and, 001 or, 111 slt
//   pc_src      out  00=ALUResult, 01=ALUOut, 10=jump target
//   pc_en       out  PC load = pc_write | (branch & zero)
//   instr_done  out  1-cycle pulse in the final state of each instruction
//   illegal_op  out  1-cycle pulse on an unsupported opcode/funct
//   mem_err     out  sticky memory-timeout flag, cleared only by reset
//   state[3:0]  out  current state encoding (debug/coverage)
//------------------------------------------------------------------------------
module mips_mc_ctrl #(
   parameter int MEM_TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       iord,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_ctrl,
   output logic [1:0] pc_src,
   output logic       pc_en,
   output logic       instr_done,
   output logic       illegal_op,
   output logic       mem_err,
   output logic [3:0] state
);

   // State encodings are visible on the debug port, so they are fixed values.
   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      FETCH   = 4'd1,
      DECODE  = 4'd2,
      MEMADR  = 4'd3,
      MEMRD   = 4'd4,
      MEMWB   = 4'd5,
      MEMWR   = 4'd6,
      EXEC    = 4'd7,
      ALUWB   = 4'd8,
      BRANCH  = 4'd9,
      ADDIEX  = 4'd10,
      ADDIWB  = 4'd11,
      JUMP    = 4'd12,
      ILLEGAL = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t     state_q;
   state_t     state_d;
   logic       pc_write;
   logic       branch;
   logic       proceed;
   logic [2:0] exec_alu;
   logic       funct_ok;

   assign state = state_q;

   // A taken branch loads the PC only when the ALU comparison came out equal.
   assign pc_en = pc_write | (branch & zero);

`ifdef MEM_WAIT_EN
   // The wait counter only needs to reach MEM_TIMEOUT-1 because the
   // timeout fires on the last held cycle, not on the one after it.
   localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   logic [CW-1:0] wait_cnt;
   logic          wait_state;
   logic          timeout;
   logic          mem_err_q;

   // Only the states that touch memory wait on the handshake.
   assign wait_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
   assign timeout    = wait_state && !mem_ready && (wait_cnt == CW'(MEM_TIMEOUT - 1));
   assign proceed    = !wait_state || mem_ready || timeout;

   // Count consecutive held cycles. A state change (or leaving a wait state)
   // resets the count, so each state entry starts a fresh timeout window.
   // mem_err stays set until the next reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wait_cnt  <= '0;
         mem_err_q <= 1'b0;
      end else begin
         if (wait_state && !proceed) begin
            wait_cnt <= wait_cnt + 1'b1;
         end else begin
            wait_cnt <= '0;
         end
         if (timeout) begin
            mem_err_q <= 1'b1;
         end
      end
   end

   assign mem_err = mem_err_q;
`else
   // Without the handshake every state takes exactly one cycle.
   logic unused_mem_ready;

   assign unused_mem_ready = mem_ready;
   assign proceed          = 1'b1;
   assign mem_err          = 1'b0;
`endif

   // State register. Reset abandons any partial instruction. IDLE drives no
   // enables, so no write can happen in the cycle after the reset edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // R-type function decode. It sets the ALU operation used in EXEC and
   // flags unsupported funct codes, which divert the FSM to ILLEGAL.
   always_comb begin
      exec_alu = ALU_ADD;
      funct_ok = 1'b1;
      case (funct)
         FN_ADD:  exec_alu = ALU_ADD;
         FN_SUB:  exec_alu = ALU_SUB;
         FN_AND:  exec_alu = ALU_AND;
         FN_OR:   exec_alu = ALU_OR;
         FN_SLT:  exec_alu = ALU_SLT;
         default: begin
            exec_alu = ALU_ADD;
            funct_ok = 1'b0;
         end
      endcase
   end

   // Next-state logic. The memory states advance only when proceed is high,
   // which is always true when the handshake feature is not built in. The two
   // unused 4-bit codes fall into the default branch and recover via IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = FETCH;
         FETCH:   state_d = proceed ? DECODE : FETCH;
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXEC;
               OP_BEQ:       state_d = BRANCH;
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JUMP;
               default:      state_d = ILLEGAL;
            endcase
         end
         MEMADR:  state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
         MEMRD:   state_d = proceed ? MEMWB : MEMRD;
         MEMWB:   state_d = FETCH;
         MEMWR:   state_d = proceed ? FETCH : MEMWR;
         EXEC:    state_d = funct_ok ? ALUWB : ILLEGAL;
         ALUWB:   state_d = FETCH;
         BRANCH:  state_d = FETCH;
         ADDIEX:  state_d = ADDIWB;
         ADDIWB:  state_d = FETCH;
         JUMP:    state_d = FETCH;
         ILLEGAL: state_d = FETCH;
         default: state_d = IDLE;
      endcase
   end

   // Moore output decode. Every output defaults to inactive with an add on
   // the ALU, and each state raises only what it needs. FETCH already
   // advanced the PC, so ILLEGAL just reports and returns to fetch.
   always_comb begin
      iord       = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_ctrl   = ALU_ADD;
      pc_src     = 2'b00;
      pc_write   = 1'b0;
      branch     = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      case (state_q)
         FETCH: begin
            ir_write  = 1'b1;
            alu_src_b = 2'b01;
            pc_write  = 1'b1;
         end
         DECODE: begin
            alu_src_b = 2'b11;
         end
         MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         MEMRD: begin
            iord = 1'b1;
         end
         MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         MEMWR: begin
            iord       = 1'b1;
            mem_write  = 1'b1;
            instr_done = 1'b1;
         end
         EXEC: begin
            alu_src_a = 1'b1;
            alu_ctrl  = exec_alu;
         end
         ALUWB: begin
            reg_dst    = 1'b1;
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         BRANCH: begin
            alu_src_a  = 1'b1;
            alu_ctrl   = ALU_SUB;
            pc_src     = 2'b01;
            branch     = 1'b1;
            instr_done = 1'b1;
         end
         ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         ADDIWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         JUMP: begin
            pc_src     = 2'b10;
            pc_write   = 1'b1;
            instr_done = 1'b1;
         end
         ILLEGAL: begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
         end
         default: begin
            alu_ctrl = ALU_ADD;
         end
      endcase
   end

endmodule
